// File: rtl/fx_ci_sequencer.sv
// fx_ci_sequencer
//   Multi-cycle custom-instruction controller for the FX floating-point
//   datapath. It sequences one shared pipelined FP multiplier and one shared
//   FP adder, both external fixed-latency units, to compute either x*y or the
//   Horner-form cubic ((c3*x + c2)*x + c1)*x + c0. It does no arithmetic itself.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   clk_en           global stall; low freezes every register
//   start, n         request strobe and operation select
//                    (0 = mul, 1 = cubic, 2/3 = pass dataa through)
//   dataa, datab     operands x and y
//   result, done     operation result and its one-cycle completion pulse
//   busy             high while an operation is in flight
//   unit_en          clock enable to both FP units (tracks clk_en)
//   mul_a/mul_b/mul_r  multiplier operands and result
//   add_a/add_b/add_r  adder operands and result
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | waiting for start
// S_MUL_ISSUE | multiplier operands on the bus (issue cycle)
// S_MUL_WAIT  | waiting MUL_LAT cycles for mul_r
// S_ADD_ISSUE | adder operands on the bus (issue cycle)
// S_ADD_WAIT  | waiting ADD_LAT cycles for add_r
// S_DONE      | done pulse, back to idle

module fx_ci_sequencer #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned ADD_LAT = 7,
  parameter logic [31:0] COEF3   = 32'h3E2AAAAB,
  parameter logic [31:0] COEF2   = 32'h3F000000,
  parameter logic [31:0] COEF1   = 32'h3F800000,
  parameter logic [31:0] COEF0   = 32'h3F800000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        unit_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_r,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_r
);

  localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  // Wait counters count down from LAT-1 to the terminal value 0, so the
  // wait state lasts exactly LAT cycles and the result is taken on the last.
  localparam logic [CNT_W-1:0] MUL_TC_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ADD_TC_LD = CNT_W'(ADD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_ISSUE = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             poly_q, poly_d;
  logic [1:0]       k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic [31:0]      coef_k;

  always_comb begin
    coef_k = COEF0;
    case (k_q)
      2'd3:    coef_k = COEF3;
      2'd2:    coef_k = COEF2;
      2'd1:    coef_k = COEF1;
      default: coef_k = COEF0;
    endcase
  end

  // Operand buses are registered, so they are loaded on the transition INTO
  // an issue state; that way they are already valid during the issue cycle.
  // In cubic mode mul_a doubles as the accumulator (it always carries acc
  // into the next multiply) and mul_b keeps x for all three multiplies.
  always_comb begin
    state_d  = state_q;
    poly_d   = poly_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (n)
            2'd0: begin
              poly_d  = 1'b0;
              mul_a_d = dataa;
              mul_b_d = datab;
              state_d = S_MUL_ISSUE;
            end
            2'd1: begin
              poly_d  = 1'b1;
              k_d     = 2'd2;
              mul_a_d = COEF3;
              mul_b_d = dataa;
              state_d = S_MUL_ISSUE;
            end
            default: begin
              result_d = dataa;
              state_d  = S_DONE;
            end
          endcase
        end
      end

      S_MUL_ISSUE: begin
        cnt_d   = MUL_TC_LD;
        state_d = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        if (cnt_q == '0) begin
          if (poly_q) begin
            add_a_d = mul_r;
            add_b_d = coef_k;
            state_d = S_ADD_ISSUE;
          end else begin
            result_d = mul_r;
            state_d  = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ADD_ISSUE: begin
        cnt_d   = ADD_TC_LD;
        state_d = S_ADD_WAIT;
      end

      S_ADD_WAIT: begin
        if (cnt_q == '0) begin
          if (k_q == 2'd0) begin
            result_d = add_r;
            state_d  = S_DONE;
          end else begin
            k_d     = k_q - 2'd1;
            mul_a_d = add_r;
            state_d = S_MUL_ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      poly_q   <= 1'b0;
      k_q      <= 2'd0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      add_a_q  <= '0;
      add_b_q  <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      poly_q   <= poly_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
    end
  end

  // The units stall in lockstep with the controller so latency counts stay aligned.
  assign unit_en = clk_en;
  assign result  = result_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;

endmodule

// File: tb/tb_fx_ci_sequencer.sv
module tb_fx_ci_sequencer;

  localparam int MUL_LAT = 5;
  localparam int ADD_LAT = 7;
  localparam logic [31:0] C3 = 32'h3E2AAAAB;
  localparam logic [31:0] C2 = 32'h3F000000;
  localparam logic [31:0] C1 = 32'h3F800000;
  localparam logic [31:0] C0 = 32'h3F800000;

  logic        clk = 1'b0;
  logic        rst, clk_en, start;
  logic [1:0]  n;
  logic [31:0] dataa, datab, result;
  logic        done, busy, unit_en;
  logic [31:0] mul_a, mul_b, mul_r, add_a, add_b, add_r;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] tr_mul_a [64];
  logic [31:0] tr_add_b [64];

  always #5 clk = ~clk;

  fx_ci_sequencer #(
    .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT),
    .COEF3(C3), .COEF2(C2), .COEF1(C1), .COEF0(C0)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done), .busy(busy),
    .unit_en(unit_en), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .add_a(add_a), .add_b(add_b), .add_r(add_r)
  );

  // IEEE single <-> real helpers (denormals flush to zero, no NaN handling)
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    logic [10:0] e;
    e = {3'd0, s[30:23]} + 11'd896;
    if (s[30:23] == 8'd0) d = {s[31], 63'd0};
    else d = {s[31], e, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [30:0] mag;
    d = $realtobits(r);
    e = d[62:52];
    if (e < 11'd897) return {d[63], 31'd0};
    if (e > 11'd1150) return {d[63], 8'hFF, 23'd0};
    mag = {e[7:0] - 8'd128, d[51:29]};
    if (d[28] && ((d[27:0] != 28'd0) || d[29])) mag = mag + 31'd1;
    return {d[63], mag};
  endfunction

  // Behavioural fixed-latency FP units, stalled by unit_en
  logic [31:0] mul_pipe [MUL_LAT];
  logic [31:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    if (unit_en) begin
      mul_pipe[0] <= r2s(s2r(mul_a) * s2r(mul_b));
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
      add_pipe[0] <= r2s(s2r(add_a) + s2r(add_b));
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign mul_r = mul_pipe[MUL_LAT-1];
  assign add_r = add_pipe[ADD_LAT-1];

  // Reference model
  function automatic int exp_lat(input logic [1:0] op);
    if (op == 2'd0) return MUL_LAT + 2;
    if (op == 2'd1) return 1 + 3 * (MUL_LAT + ADD_LAT + 2);
    return 1;
  endfunction

  function automatic logic [31:0] exp_res(input logic [1:0] op, input logic [31:0] a, b);
    real x;
    x = s2r(a);
    if (op == 2'd0) return r2s(x * s2r(b));
    if (op == 2'd1) return r2s(((s2r(C3) * x + s2r(C2)) * x + s2r(C1)) * x + s2r(C0));
    return a;
  endfunction

  function automatic int ulp_dist(input logic [31:0] a, b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [31:0] rand_fp(input int emin, input int emax, input bit neg_ok);
    logic [31:0] v;
    v[31]    = neg_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    v[30:23] = 8'($urandom_range(emin, emax));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  // Issue one request and wait (bounded) for done. Cycle j is sampled at the
  // j-th falling edge after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit spur, input int st_from, input int st_len, input int extra_cyc,
                        output int lat, output logic [31:0] res, output int busy_bad);
    lat = -1;
    res = '0;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; n = op; dataa = a; datab = b; clk_en = 1'b1;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      start = 1'b0;
      n = 2'($urandom); dataa = $urandom; datab = $urandom;
      if (j < 64) begin
        tr_mul_a[j] = mul_a;
        tr_add_b[j] = add_b;
      end
      if (done === 1'b1) begin
        lat = j;
        res = result;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== (op < 2'd2)) busy_bad++;
      clk_en = !(st_len > 0 && j >= st_from && j < st_from + st_len);
      if (spur && $urandom_range(0, 2) == 0) start = 1'b1;
      if (j == extra_cyc) start = 1'b1;
    end
    start = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00 || result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_out: done=%b busy=%b result=%h, want 0 0 0", done, busy, result);
    end
    n_cmp++;
    if (mul_a !== 32'd0 || mul_b !== 32'd0 || add_a !== 32'd0 || add_b !== 32'd0) begin
      n_err++;
      $display("FAIL reset_bus: %h %h %h %h, want all 0", mul_a, mul_b, add_a, add_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bb;
    logic [31:0] res;
    run_op(2'd0, 32'h42800000, 32'h40000000, 1'b0, 0, 0, 0, lat, res, bb);
    n_cmp++;
    if (lat !== 7) begin n_err++; $display("FAIL mul_lat: got %0d want 7", lat); end
    n_cmp++;
    if (res !== 32'h43000000) begin n_err++; $display("FAIL mul_res: got %h want 43000000", res); end
    n_cmp++;
    if (bb !== 0) begin n_err++; $display("FAIL mul_busy: %0d bad cycles, want 0", bb); end
  endtask

  task automatic test_poly();
    int lat, bb, per, mi, ai;
    logic [31:0] res;
    logic [31:0] exp_mul [3];
    logic [31:0] exp_add [3];
    exp_mul[0] = C3; exp_mul[1] = C2; exp_mul[2] = C1;
    exp_add[0] = C2; exp_add[1] = C1; exp_add[2] = C0;
    per = MUL_LAT + ADD_LAT + 2;
    run_op(2'd1, 32'h00000000, 32'h0, 1'b0, 0, 0, 0, lat, res, bb);
    n_cmp++;
    if (lat !== 43) begin n_err++; $display("FAIL poly0_lat: got %0d want 43", lat); end
    n_cmp++;
    if (res !== 32'h3F800000) begin n_err++; $display("FAIL poly0_res: got %h want 3f800000", res); end
    n_cmp++;
    if (bb !== 0) begin n_err++; $display("FAIL poly0_busy: %0d bad cycles, want 0", bb); end
    for (int i = 0; i < 3; i++) begin
      mi = 1 + i * per;
      ai = mi + 1 + MUL_LAT;
      n_cmp++;
      if (tr_mul_a[mi] !== exp_mul[i]) begin
        n_err++; $display("FAIL poly0_mul_a[%0d]: got %h want %h", i, tr_mul_a[mi], exp_mul[i]);
      end
      n_cmp++;
      if (tr_add_b[ai] !== exp_add[i]) begin
        n_err++; $display("FAIL poly0_add_b[%0d]: got %h want %h", i, tr_add_b[ai], exp_add[i]);
      end
    end
    run_op(2'd1, 32'h3F800000, 32'h0, 1'b0, 0, 0, 0, lat, res, bb);
    n_cmp++;
    if (lat !== 43) begin n_err++; $display("FAIL poly1_lat: got %0d want 43", lat); end
    n_cmp++;
    if (ulp_dist(res, 32'h402AAAAB) > 2) begin
      n_err++; $display("FAIL poly1_res: got %h want 402aaaab +-2ulp", res);
    end
  endtask

  task automatic test_stall();
    int lat, bb, dcnt, bcnt;
    logic [31:0] res;
    run_op(2'd0, 32'h42800000, 32'h40000000, 1'b0, 4, 4, 3, lat, res, bb);
    n_cmp++;
    if (lat !== 11) begin n_err++; $display("FAIL stall_lat: got %0d want 11", lat); end
    n_cmp++;
    if (res !== 32'h43000000) begin n_err++; $display("FAIL stall_res: got %h want 43000000", res); end
    dcnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0) begin n_err++; $display("FAIL stall_extra_done: got %0d want 0", dcnt); end

    // done and unit_en under a stall in DONE
    @(negedge clk);
    start = 1'b1; n = 2'd2; dataa = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; clk_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || unit_en !== 1'b0) begin
      n_err++; $display("FAIL stall_done_hold: done=%b unit_en=%b, want 1 0", done, unit_en);
    end
    clk_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || result !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL stall_done_release: done=%b result=%h, want 0 cafef00d", done, result);
    end

    // start with clk_en low is lost
    start = 1'b1; n = 2'd0; clk_en = 1'b0;
    @(negedge clk);
    start = 1'b0; clk_en = 1'b1;
    bcnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) bcnt++;
    end
    n_cmp++;
    if (bcnt !== 0) begin n_err++; $display("FAIL stalled_start: %0d active cycles, want 0", bcnt); end
  endtask

  task automatic test_reset_abort();
    int lat, bb, dcnt;
    logic [31:0] res;
    @(negedge clk);
    start = 1'b1; n = 2'd1; dataa = 32'h3F800000;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (result !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || mul_a !== 32'd0) begin
      n_err++;
      $display("FAIL abort_clear: result=%h busy=%b done=%b mul_a=%h, want 0", result, busy, done, mul_a);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    n_cmp++;
    if (dcnt !== 0) begin n_err++; $display("FAIL abort_quiet: %0d active cycles, want 0", dcnt); end
    run_op(2'd0, 32'h42800000, 32'h40000000, 1'b0, 0, 0, 0, lat, res, bb);
    n_cmp++;
    if (lat !== 7 || res !== 32'h43000000) begin
      n_err++; $display("FAIL abort_recover: lat=%0d res=%h, want 7 43000000", lat, res);
    end
  endtask

  task automatic test_bypass();
    int lat, bb;
    logic [31:0] res;
    logic [127:0] bus0;
    bus0 = {mul_a, mul_b, add_a, add_b};
    run_op(2'd2, 32'h12345678, 32'h0, 1'b0, 0, 0, 0, lat, res, bb);
    n_cmp++;
    if (lat !== 1 || res !== 32'h12345678) begin
      n_err++; $display("FAIL bypass: lat=%0d res=%h, want 1 12345678", lat, res);
    end
    n_cmp++;
    if ({mul_a, mul_b, add_a, add_b} !== bus0) begin
      n_err++; $display("FAIL bypass_bus: got %h want %h", {mul_a, mul_b, add_a, add_b}, bus0);
    end
  endtask

  task automatic test_random();
    int lat, bb, sf, sl, elat;
    logic [1:0] op;
    logic [31:0] a, b, res, er;
    for (int t = 0; t < 30; t++) begin
      op = 2'($urandom_range(0, 3));
      a = (op == 2'd1) ? rand_fp(118, 130, 1'b0) : rand_fp(110, 140, 1'b1);
      b = rand_fp(110, 140, 1'b1);
      sf = $urandom_range(2, 6);
      sl = $urandom_range(0, 3);
      elat = exp_lat(op) + ((op < 2'd2) ? sl : 0);
      er = exp_res(op, a, b);
      run_op(op, a, b, 1'b1, sf, sl, 0, lat, res, bb);
      n_cmp++;
      if (lat !== elat) begin
        n_err++; $display("FAIL rand_lat[%0d] n=%0d: got %0d want %0d", t, op, lat, elat);
      end
      n_cmp++;
      if ((op == 2'd1) ? (ulp_dist(res, er) > 4) : (res !== er)) begin
        n_err++; $display("FAIL rand_res[%0d] n=%0d: got %h want %h", t, op, res, er);
      end
      n_cmp++;
      if (bb !== 0) begin
        n_err++; $display("FAIL rand_busy[%0d]: %0d bad cycles, want 0", t, bb);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; start = 1'b0; n = 2'd0; dataa = '0; datab = '0;
    test_reset();
    test_mul();
    test_poly();
    test_stall();
    test_reset_abort();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fx_ci_sequencer.md
Name: fx_ci_sequencer

Overview:
Nios II multi-cycle custom-instruction controller for the FX floating-point datapath. It accepts a start/n/dataa/datab request and sequences one shared pipelined FP multiplier and one shared FP adder, both external fixed-latency units. Supported operations are a plain multiply and a Horner-form cubic polynomial evaluation. It returns `result` with a one-cycle `done` pulse.

Parameters:
- MUL_LAT, 5, FP multiplier latency in clock cycles, valid range ≥1.
- ADD_LAT, 7, FP adder latency in clock cycles, valid range ≥1.
- COEF3, 32'h3E2AAAAB, IEEE-754 single coefficient c3 (1/6).
- COEF2, 32'h3F000000, coefficient c2 (0.5).
- COEF1, 32'h3F800000, coefficient c1 (1.0).
- COEF0, 32'h3F800000, coefficient c0 (1.0).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- clk_en, in, 1, global stall; low freezes all state.
- start, in, 1, one-cycle request strobe, qualified by clk_en.
- n, in, 2, operation select.
- dataa, in, 32, operand x (IEEE single).
- datab, in, 32, operand y (IEEE single).
- result, out, 32, operation result.
- done, out, 1, one-cycle completion pulse.
- busy, out, 1, high from the cycle after an accepted start until done.
- unit_en, out, 1, clock enable to both FP units, equal to clk_en.
- mul_a, out, 32, multiplier operand A.
- mul_b, out, 32, multiplier operand B.
- mul_r, in, 32, multiplier result.
- add_a, out, 32, adder operand A.
- add_b, out, 32, adder operand B.
- add_r, in, 32, adder result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; result, done, busy = 0.
  - mul_a, mul_b, add_a, add_b = 0; accumulator and counters = 0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- clk_en=0: state, counters, registers and outputs hold their values; done holds its value. unit_en=0 stalls the units in lockstep, so latency counts are preserved.
- States: IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, DONE.
- Timing conventions:
  - Cycle 0 is the cycle in which start=1 is sampled in IDLE.
  - Unit timing: operands driven in issue cycle c give a result valid in cycle c+LAT, and the controller captures it at the end of that cycle.
- IDLE, start=1, by n:
  - n=0: latch x=dataa, y=datab; go to MUL_ISSUE.
  - n=1: latch x=dataa; acc=COEF3; k=2; go to MUL_ISSUE.
  - n=2 or n=3: result=dataa; go to DONE. done is asserted in cycle 1.
- MUL_ISSUE (1 cycle):
  - Drive mul_a = (n=0 ? x : acc) and mul_b = (n=0 ? y : x).
  - Clear the wait counter; go to MUL_WAIT.
- MUL_WAIT: count to MUL_LAT, then capture mul_r.
  - n=0: result=mul_r; go to DONE.
  - n=1: tmp=mul_r; go to ADD_ISSUE.
- ADD_ISSUE (1 cycle):
  - Drive add_a=tmp and add_b=COEF[k].
  - Go to ADD_WAIT.
- ADD_WAIT: count to ADD_LAT, then acc=add_r.
  - If k=0: result=add_r; go to DONE.
  - Else: k=k-1; go to MUL_ISSUE.
- DONE (1 cycle): done=1; busy=0 next; go to IDLE. done is 0 in every other state.
- Latency (start cycle to done cycle):
  - n=0: MUL_LAT+2, which is 7 at defaults.
  - n=1: 1+3*(MUL_LAT+ADD_LAT+2), which is 43 at defaults.
  - n=2 or n=3: 1.
- Operand buses hold their last driven value outside issue cycles.
- result holds its value until the next completion.
- start while busy, or while in DONE, is ignored. No queuing; the request is lost.
- start together with clk_en=0 is ignored.
- The controller performs no FP arithmetic of its own.
  - NaN, Inf and denormal handling is delegated to the units.
  - Coefficient and operand widths are a fixed 32 bits.

Test Plan:
- Default parameters, behavioural unit models: dataa=32'h42800000 (64.0), datab=32'h40000000 (2.0), n=0, start for 1 cycle → done exactly 7 cycles later, result=32'h43000000 (128.0); busy high for cycles 1–6.
- n=1, dataa=32'h00000000 (0.0) → done at cycle 43, result=32'h3F800000 (1.0). Check mul_a/add_b sequence: COEF3 then COEF2, COEF1, COEF0.
- n=1, dataa=32'h3F800000 (1.0) → done at cycle 43, result 2.6667 (32'h402AAAAB ±2 ulp).
- Stall and late start: n=0 as in the first scenario, clk_en=0 for 4 cycles in the middle of MUL_WAIT → done at cycle 11, result unchanged. A second start pulsed at cycle 3 is ignored, so there is exactly one done.
- Reset abort: n=1 start, rst=1 asynchronously at cycle 20 → immediately result=0, busy=0, done=0, state IDLE. No done pulse follows. A new n=0 start afterwards completes normally in 7 cycles.
- Bypass: n=2, dataa=32'h12345678 → done at cycle 1, result=32'h12345678; no change on mul_a, mul_b, add_a or add_b.
